// File: rtl/isqrt_dbd_pipe_pkg.sv
// ---------------------------------------------------------------------------
// isqrt_pkg
// Shared sizing helpers for the digit-by-digit square-root pipeline.
//   even_width   : radicand width rounded up to an even number of bits
//   half_width   : number of root bits (one digit iteration per root bit)
//   stage_count  : register stages for a given iterations-per-stage grouping
//   iters_divide : legality check, iterations per stage must divide N
// ---------------------------------------------------------------------------
package isqrt_pkg;

    function automatic int even_width(input int dw);
        return dw + (dw % 32'sd2);
    endfunction

    function automatic int half_width(input int dw);
        return even_width(dw) / 32'sd2;
    endfunction

    function automatic int stage_count(input int dw, input int ips);
        return half_width(dw) / ips;
    endfunction

    function automatic bit iters_divide(input int dw, input int ips);
        return (ips >= 32'sd1) && ((half_width(dw) % ips) == 32'sd0);
    endfunction

endpackage

// File: rtl/isqrt_dbd_pipe_stage.sv
// ---------------------------------------------------------------------------
// isqrt_dbd_stage
// One register stage of the square-root pipeline: ITERS_PER_STAGE digit
// iterations (starting at global iteration FIRST_ITER) evaluated
// combinationally, followed by the valid/x/y/tag register.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_en            global advance; all registers hold when low
//   i_valid         sample valid from the previous stage
//   i_x, i_y        partial remainder / partial root from the previous stage
//   i_tag           sideband tag from the previous stage
//   o_valid, o_x, o_y, o_tag  registered stage outputs
// ---------------------------------------------------------------------------
module isqrt_dbd_stage #(
    parameter int WIDTH           = 32,
    parameter int ITERS_PER_STAGE = 1,
    parameter int FIRST_ITER      = 0,
    parameter int TAG_WIDTH       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic                 i_valid,
    input  logic [WIDTH-1:0]     i_x,
    input  logic [WIDTH-1:0]     i_y,
    input  logic [TAG_WIDTH-1:0] i_tag,
    output logic                 o_valid,
    output logic [WIDTH-1:0]     o_x,
    output logic [WIDTH-1:0]     o_y,
    output logic [TAG_WIDTH-1:0] o_tag
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]     w_x;
    logic [WIDTH-1:0]     w_y;
    logic [WIDTH-1:0]     w_m;
    logic [WIDTH-1:0]     w_b;

    logic                 r_valid;
    logic [WIDTH-1:0]     r_x;
    logic [WIDTH-1:0]     r_y;
    logic [TAG_WIDTH-1:0] r_tag;

    // Digit iterations for this stage; the trial bit m walks down two bits per iteration.
    always_comb begin
        w_x = i_x;
        w_y = i_y;
        w_m = '0;
        w_b = '0;
        for (int k = 0; k < ITERS_PER_STAGE; k++) begin
            w_m = ONE << (WIDTH - 2 - 2 * (FIRST_ITER + k));
            w_b = w_y | w_m;
            if (w_x >= w_b) begin
                w_x = w_x - w_b;
                w_y = (w_y >> 1) | w_m;
            end else begin
                w_y = w_y >> 1;
            end
        end
    end

    // Stage register; data only loads for valid samples so outputs stay at
    // zero after reset until the first real result reaches them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_tag   <= '0;
        end else if (i_en) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_x   <= w_x;
                r_y   <= w_y;
                r_tag <= i_tag;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_x     = r_x;
    assign o_y     = r_y;
    assign o_tag   = r_tag;

endmodule

// File: rtl/isqrt_dbd_pipe.sv
// ---------------------------------------------------------------------------
// isqrt_dbd_pipe
// Fully pipelined digit-by-digit integer square root, one sample per cycle,
// with valid/ready flow control and a sideband tag.
// Ports:
//   clk, rst                clock, asynchronous active-high reset
//   in_valid/in_ready       input handshake (in_ready depends only on output state)
//   in_data, in_tag         unsigned radicand and user tag
//   out_valid/out_ready     output handshake
//   out_root                floor(sqrt(in_data))
//   out_rem                 in_data - out_root^2
//   out_tag                 tag of the sample producing this result
// ---------------------------------------------------------------------------
module isqrt_dbd_pipe
    import isqrt_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ITERS_PER_STAGE = 1,
    parameter int TAG_WIDTH       = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_WIDTH-1:0]             in_data,
    input  logic [TAG_WIDTH-1:0]              in_tag,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [half_width(DATA_WIDTH)-1:0] out_root,
    output logic [half_width(DATA_WIDTH):0]   out_rem,
    output logic [TAG_WIDTH-1:0]              out_tag
);

    localparam int WIDTH  = even_width(DATA_WIDTH);
    localparam int N      = half_width(DATA_WIDTH);
    localparam int STAGES = stage_count(DATA_WIDTH, ITERS_PER_STAGE);

    if (!iters_divide(DATA_WIDTH, ITERS_PER_STAGE)) begin : g_bad_iters
        $error("isqrt_dbd_pipe: ITERS_PER_STAGE must divide half the even-rounded DATA_WIDTH");
    end

    // Chain index s is the input of stage s; index STAGES is the last register.
    logic                 w_valid [0:STAGES];
    logic [WIDTH-1:0]     w_x     [0:STAGES];
    logic [WIDTH-1:0]     w_y     [0:STAGES];
    logic [TAG_WIDTH-1:0] w_tag   [0:STAGES];
    logic                 w_en;

    // The whole pipe advances unless a result is waiting and not taken.
    assign w_en     = !w_valid[STAGES] || out_ready;
    assign in_ready = w_en;

    assign w_valid[0] = in_valid;
    assign w_x[0]     = WIDTH'(in_data);
    assign w_y[0]     = '0;
    assign w_tag[0]   = in_tag;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        isqrt_dbd_stage #(
            .WIDTH          (WIDTH),
            .ITERS_PER_STAGE(ITERS_PER_STAGE),
            .FIRST_ITER     (s * ITERS_PER_STAGE),
            .TAG_WIDTH      (TAG_WIDTH)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .i_en   (w_en),
            .i_valid(w_valid[s]),
            .i_x    (w_x[s]),
            .i_y    (w_y[s]),
            .i_tag  (w_tag[s]),
            .o_valid(w_valid[s+1]),
            .o_x    (w_x[s+1]),
            .o_y    (w_y[s+1]),
            .o_tag  (w_tag[s+1])
        );
    end

    // Outputs come straight from the last stage register.
    assign out_valid = w_valid[STAGES];
    assign out_root  = w_y[STAGES][N-1:0];
    assign out_rem   = w_x[STAGES][N:0];
    assign out_tag   = w_tag[STAGES];

endmodule

// File: tb/tb_isqrt_dbd_pipe.sv
// ---------------------------------------------------------------------------
// tb_isqrt_dbd_pipe
// Self-checking bench for isqrt_dbd_pipe: a 32-bit / 1 iteration-per-stage
// instance (a_*) and a 7-bit / 2 iterations-per-stage instance (b_*).
// A reference model computes floor(sqrt) by binary search on plain integers;
// per-instance scoreboards check every output handshake in order.
// ---------------------------------------------------------------------------
module tb_isqrt_dbd_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data;
    logic [3:0]  a_in_tag, a_out_tag;
    logic [15:0] a_out_root;
    logic [16:0] a_out_rem;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [6:0]  b_in_data;
    logic [3:0]  b_in_tag, b_out_tag;
    logic [3:0]  b_out_root;
    logic [4:0]  b_out_rem;

    isqrt_dbd_pipe #(.DATA_WIDTH(32), .ITERS_PER_STAGE(1), .TAG_WIDTH(4)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_root(a_out_root), .out_rem(a_out_rem), .out_tag(a_out_tag)
    );

    isqrt_dbd_pipe #(.DATA_WIDTH(7), .ITERS_PER_STAGE(2), .TAG_WIDTH(4)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_root(b_out_root), .out_rem(b_out_rem), .out_tag(b_out_tag)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: largest r with r*r <= v, by binary search.
    function automatic longint ref_root(input longint v, input int w);
        longint lo, hi, mid;
        lo = 0;
        hi = (64'sd1 <<< ((w + 1) / 2)) - 1;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= v) lo = mid;
            else hi = mid - 1;
        end
        return lo;
    endfunction

    typedef struct {
        longint     root;
        longint     rem;
        logic [3:0] tag;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_res_a = 0;
    int   n_res_b = 0;

    // Scoreboard / stall-stability monitor for instance a.
    logic        stall_a = 1'b0;
    logic [15:0] hold_root_a;
    logic [16:0] hold_rem_a;
    logic [3:0]  hold_tag_a;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q_a.delete();
            stall_a = 1'b0;
        end else begin
            if (stall_a) begin
                chk("a_hold_valid", a_out_valid, 1);
                chk("a_hold_root", a_out_root, hold_root_a);
                chk("a_hold_rem", a_out_rem, hold_rem_a);
                chk("a_hold_tag", a_out_tag, hold_tag_a);
            end
            if (a_out_valid && a_out_ready) begin
                chk("a_result_expected", (q_a.size() != 0), 1);
                if (q_a.size() != 0) begin
                    e = q_a.pop_front();
                    n_res_a++;
                    chk("a_root", a_out_root, e.root);
                    chk("a_rem", a_out_rem, e.rem);
                    chk("a_tag", a_out_tag, e.tag);
                end
            end
            if (a_in_valid && a_in_ready) begin
                e.root = ref_root(longint'(a_in_data), 32);
                e.rem  = longint'(a_in_data) - e.root * e.root;
                e.tag  = a_in_tag;
                q_a.push_back(e);
            end
            stall_a     = a_out_valid && !a_out_ready;
            hold_root_a = a_out_root;
            hold_rem_a  = a_out_rem;
            hold_tag_a  = a_out_tag;
        end
    end

    // Scoreboard / stall-stability monitor for instance b.
    logic       stall_b = 1'b0;
    logic [3:0] hold_root_b;
    logic [4:0] hold_rem_b;
    logic [3:0] hold_tag_b;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q_b.delete();
            stall_b = 1'b0;
        end else begin
            if (stall_b) begin
                chk("b_hold_valid", b_out_valid, 1);
                chk("b_hold_root", b_out_root, hold_root_b);
                chk("b_hold_rem", b_out_rem, hold_rem_b);
                chk("b_hold_tag", b_out_tag, hold_tag_b);
            end
            if (b_out_valid && b_out_ready) begin
                chk("b_result_expected", (q_b.size() != 0), 1);
                if (q_b.size() != 0) begin
                    e = q_b.pop_front();
                    n_res_b++;
                    chk("b_root", b_out_root, e.root);
                    chk("b_rem", b_out_rem, e.rem);
                    chk("b_tag", b_out_tag, e.tag);
                end
            end
            if (b_in_valid && b_in_ready) begin
                e.root = ref_root(longint'(b_in_data), 7);
                e.rem  = longint'(b_in_data) - e.root * e.root;
                e.tag  = b_in_tag;
                q_b.push_back(e);
            end
            stall_b     = b_out_valid && !b_out_ready;
            hold_root_b = b_out_root;
            hold_rem_b  = b_out_rem;
            hold_tag_b  = b_out_tag;
        end
    end

    task automatic send_a(input logic [31:0] d, input logic [3:0] t);
        int n;
        a_in_valid = 1'b1;
        a_in_data  = d;
        a_in_tag   = t;
        n = 0;
        while (!a_in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("a_send_ready", a_in_ready, 1);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [6:0] d, input logic [3:0] t);
        int n;
        b_in_valid = 1'b1;
        b_in_data  = d;
        b_in_tag   = t;
        n = 0;
        while (!b_in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b_send_ready", b_in_ready, 1);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    task automatic wait_a(output int cyc);
        cyc = 0;
        while (!a_out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic wait_b(output int cyc);
        cyc = 0;
        while (!b_out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int stale;
        logic [15:0] held_root;
        logic [3:0]  held_tag;

        rst = 1'b1;
        a_in_valid = 1'b0; a_in_data = '0; a_in_tag = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_tag = '0; b_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("a_rst_valid", a_out_valid, 0);
        chk("a_rst_root", a_out_root, 0);
        chk("a_rst_rem", a_out_rem, 0);
        chk("a_rst_tag", a_out_tag, 0);
        chk("a_rst_in_ready", a_in_ready, 1);
        chk("b_rst_valid", b_out_valid, 0);
        chk("b_rst_root", b_out_root, 0);
        chk("b_rst_rem", b_out_rem, 0);
        rst = 1'b0;
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        @(posedge clk); #1;

        // Zero radicand, latency of 16 register stages
        send_a(32'd0, 4'd3);
        wait_a(cyc);
        chk("a_latency", cyc, 15);
        chk("a_zero_root", a_out_root, 0);
        chk("a_zero_rem", a_out_rem, 0);
        chk("a_zero_tag", a_out_tag, 3);

        // Maximum radicand
        send_a(32'hFFFF_FFFF, 4'd5);
        wait_a(cyc);
        chk("a_max_root", a_out_root, 16'hFFFF);
        chk("a_max_rem", a_out_rem, 17'h1FFFE);
        chk("a_max_tag", a_out_tag, 5);

        // Back-to-back 15, 16, 17
        a_in_valid = 1'b1; a_in_data = 32'd15; a_in_tag = 4'd1;
        @(posedge clk); #1;
        a_in_data = 32'd16; a_in_tag = 4'd2;
        @(posedge clk); #1;
        a_in_data = 32'd17; a_in_tag = 4'd3;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        wait_a(cyc);
        chk("a_b2b0", {a_out_root, a_out_rem, a_out_tag}, {16'd3, 17'd6, 4'd1});
        @(posedge clk); #1;
        chk("a_b2b1_valid", a_out_valid, 1);
        chk("a_b2b1", {a_out_root, a_out_rem, a_out_tag}, {16'd4, 17'd0, 4'd2});
        @(posedge clk); #1;
        chk("a_b2b2_valid", a_out_valid, 1);
        chk("a_b2b2", {a_out_root, a_out_rem, a_out_tag}, {16'd4, 17'd1, 4'd3});
        repeat (3) @(posedge clk);
        #1;

        // Fill pipeline with output stalled, then hold 5 cycles
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        for (int i = 0; i < 24; i++) begin
            a_in_data = $urandom;
            a_in_tag  = 4'(i);
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        chk("a_full_in_ready", a_in_ready, 0);
        chk("a_full_out_valid", a_out_valid, 1);
        held_root = a_out_root;
        held_tag  = a_out_tag;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("a_stall_in_ready", a_in_ready, 0);
            chk("a_stall_root", a_out_root, held_root);
            chk("a_stall_tag", a_out_tag, held_tag);
        end
        a_out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("a_drain_empty", q_a.size(), 0);
        chk("a_drain_valid", a_out_valid, 0);

        // Reset in the middle of a stream
        a_in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a_in_data = $urandom;
            a_in_tag  = 4'($urandom_range(0, 15));
            @(posedge clk); #1;
        end
        chk("a_pre_rst_valid", a_out_valid, 1);
        rst = 1'b1;
        a_in_valid = 1'b0;
        #1;
        chk("a_midrst_valid", a_out_valid, 0);
        chk("a_midrst_root", a_out_root, 0);
        chk("a_midrst_rem", a_out_rem, 0);
        chk("a_midrst_tag", a_out_tag, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        stale = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (a_out_valid) stale++;
        end
        chk("a_no_stale", stale, 0);
        send_a(32'd200, 4'd9);
        wait_a(cyc);
        chk("a_post_rst_latency", cyc, 15);
        chk("a_post_rst", {a_out_root, a_out_rem, a_out_tag}, {16'd14, 17'd4, 4'd9});
        @(posedge clk); #1;

        // Random sweep on instance a, with boundary values mixed in
        for (int i = 0; i < 150; i++) begin
            a_in_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       a_in_data = 32'd0;
                1:       a_in_data = 32'hFFFF_FFFF;
                2:       a_in_data = 32'($urandom_range(0, 65535)) * 32'($urandom_range(0, 65535));
                default: a_in_data = $urandom;
            endcase
            a_in_tag    = 4'($urandom_range(0, 15));
            a_out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("a_rand_empty", q_a.size(), 0);
        chk("a_results_seen", (n_res_a > 100), 1);

        // 7-bit instance, 2 iterations per stage
        send_b(7'd127, 4'd6);
        wait_b(cyc);
        chk("b_latency", cyc, 1);
        chk("b_127", {b_out_root, b_out_rem, b_out_tag}, {4'd11, 5'd6, 4'd6});
        @(posedge clk); #1;
        for (int i = 0; i < 300; i++) begin
            b_in_valid  = ($urandom_range(0, 3) != 0);
            b_in_data   = 7'($urandom_range(0, 127));
            b_in_tag    = 4'($urandom_range(0, 15));
            b_out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("b_rand_empty", q_b.size(), 0);
        chk("b_results_seen", (n_res_b > 150), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/isqrt_dbd_pipe.md
Name: isqrt_dbd_pipe

Overview:
Parametrised, fully pipelined digit-by-digit integer square root with valid/ready flow control, a per-sample sideband tag and remainder output. It generalises the fixed one-iteration-per-register square-root pipeline. The number of iterations per register stage is configurable so the team can trade latency against timing. It sits in arithmetic datapaths (DSP magnitude, norm computation) and accepts one sample per cycle.

Parameters:
DATA_WIDTH, 32, radicand width (odd allowed; internally zero-extended to even WIDTH = DATA_WIDTH rounded up to even; N = WIDTH/2)
ITERS_PER_STAGE, 1, digit iterations combined per register stage; must divide N (elaboration error otherwise)
TAG_WIDTH, 4, sideband tag width carried alongside each sample (>=1)
Derived: STAGES = N / ITERS_PER_STAGE

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input sample present
in_ready  out  1  block can accept input this cycle
in_data  in  DATA_WIDTH  unsigned radicand
in_tag  in  TAG_WIDTH  user tag, returned unchanged with result
out_valid  out  1  result present
out_ready  in  1  downstream accepts result
out_root  out  N  floor(sqrt(in_data))
out_rem  out  N+1  in_data - out_root^2 (range 0..2*out_root)
out_tag  out  TAG_WIDTH  tag of the sample producing this result

Behaviour:
- Reset (async assert, sync-to-clk release): every stage valid flag, partial remainder, partial root, tag register cleared to 0; out_valid=0, out_root=0, out_rem=0, out_tag=0. In-flight samples are discarded; no result for them ever appears.
- Global advance: en = !out_valid || out_ready. in_ready = en (combinational, from out_valid/out_ready only; no path from in_valid).
- Accept: in_valid && in_ready at a rising edge.
- When en=1, every stage register loads from its predecessor (stage 0 loads from in_data/in_tag, with valid = in_valid). When en=0, all stages hold; out_* stable while out_valid && !out_ready.
- Bubbles are not collapsed; a stage with valid=0 still shifts.
- Latency: result for a sample accepted at edge k shows out_valid=1 after edge k+STAGES-1 (i.e. STAGES register stages, stage STAGES-1 drives outputs) when no stall occurs. Throughput 1 sample/cycle.
- Iteration i (0..N-1), bit m_i = 1 << (WIDTH-2-2i): b = y | m_i; if x >= b then x -= b, y = (y>>1) | m_i else y = y>>1. Initial x = zero-extended in_data, y = 0. Stage s performs iterations s*ITERS_PER_STAGE .. (s+1)*ITERS_PER_STAGE-1 combinationally, then registers.
- Final: out_root = y[N-1:0], out_rem = x[N:0]. Internal x, y sized WIDTH bits (no fixed 32-bit vectors); all compares unsigned.
- Data registers of invalid stages may hold any value, but outputs must read 0 after reset until the first valid result.
- Simultaneous accept and output handshake in one cycle: both occur; pipeline advances one step.
- Stall with pipeline full: in_ready=0; no sample lost, none duplicated.

Decomposition:
- Package isqrt_pkg: function for even-rounded width, half width, stage count; localparam check helper for ITERS_PER_STAGE divisibility.
- One sub-module isqrt_dbd_stage (params WIDTH, ITERS_PER_STAGE, FIRST_ITER, TAG_WIDTH): combinational iterations plus valid/x/y/tag register with en and async rst. Top generates STAGES instances and the handshake.

Test Plan:
- DATA_WIDTH=32, ITERS=1: in_data=0, tag=3 -> after 16 cycles out_valid=1, root=0, rem=0, tag=3.
- in_data=0xFFFFFFFF -> root=0xFFFF, rem=0x1FFFE.
- Back-to-back 15,16,17 (tags 1,2,3), out_ready=1 -> consecutive results root/rem 3/6, 4/0, 4/1 with tags 1,2,3.
- Full pipeline, out_ready=0 for 5 cycles -> in_ready=0, outputs held stable; after release all samples emerge in order once each.
- DATA_WIDTH=7, ITERS_PER_STAGE=2: in_data=127 -> root=11, rem=6 after 2 cycles; random sweep matches reference model.
- rst asserted mid-stream for 1 cycle -> out_valid drops immediately, outputs 0; no stale results afterwards; new input after release gives correct result.
